rom_mac_sequencer: RTL
======================

# rom_mac_sequencer

Sequencer that computes a dot product of `N_TERMS` pairs of 4-bit operands using the ROM multiplier.
- Accepts operand pairs on a valid/ready stream.
- Packs each pair into a ROM address, issues the lookup, and waits out the ROM's one-cycle registered latency.
- Accumulates the 8-bit products and presents the sum on an output valid/ready port.
- Sits directly upstream (address/enable driver) and downstream (data consumer) of `ROM_multiplier`, connected at the parent level.

## Interface
- `N_TERMS`, default 4: products per dot product; legal range 1..16.
- `ACC_W`, default 12: accumulator width; must be ≥ 8 + clog2(N_TERMS), checked by an elaboration-time assertion.

- `clk`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  begin a new dot product; honoured only in IDLE.
- `In_Valid`  in  1  operand pair valid.
- `In_Ready`  out  1  sequencer can take a pair.
- `In_A`  in  4  multiplicand.
- `In_B`  in  4  multiplier.
- `Rom_Enable`  out  1  to ROM `Enable`; registered.
- `Rom_Address`  out  8  to ROM `Address` = {A,B}; registered.
- `Rom_Data`  in  8  from ROM `Data`; product, valid one cycle after the enabled edge.
- `Out_Valid`  out  1  `Out_Sum` valid.
- `Out_Ready`  in  1  consumer accepts the sum.
- `Out_Sum`  out  `ACC_W`  accumulated sum.
- `Busy`  out  1  state ≠ IDLE.

## Operation
**IDLE**
- `In_Ready`=0, `Out_Valid`=0.
- `Start`=1: clear acc and count, go to COLLECT.

**COLLECT**
- `In_Ready`=1.
- On `In_Valid`&&`In_Ready`: `Rom_Address`<={`In_A`,`In_B`}, `Rom_Enable`<=1, go to LOOKUP.

**LOOKUP**
- `Rom_Enable`=1 during this cycle; the ROM samples at its end edge.
- Next: `Rom_Enable`<=0, go to ACCUM.

**ACCUM**
- acc <= acc + zero-extended `Rom_Data`.
- count==`N_TERMS`-1: go to DONE. Otherwise count++ and go to COLLECT.

**DONE**
- `Out_Valid`=1.
- On `Out_Ready`: go to IDLE.
- acc, and therefore `Out_Sum`, holds until the next `Start`.

**General rules**
- `Out_Sum` is driven directly from acc at all times.
- `In_Ready`=0 in LOOKUP, ACCUM and DONE; `In_Valid` outside COLLECT is ignored.
- `Start` outside IDLE is ignored.
- `Rom_Address` holds its last value when `Rom_Enable`=0.
- Arithmetic is unsigned, modulo 2^`ACC_W`. No overflow is possible within the legal parameter range (max 16·225=3600 < 4096).

## Timing
- Reset values:
  - `In_Ready`=0, `Rom_Enable`=0, `Rom_Address`=0, `Out_Valid`=0, `Out_Sum`=0, `Busy`=0.
  - state=IDLE, count=0.
- Throughput: one pair per 3 cycles (COLLECT→LOOKUP→ACCUM), plus upstream stall cycles.
- Latency: with the last operand handshake at edge E, `Rom_Enable` is high in cycle E..E+1. The ROM captures the product at E+1, acc updates at E+2, and `Out_Valid`=1 from just after E+2.
- Output handshake: the sum transfers on the edge where `Out_Valid`&&`Out_Ready`.
  - `Out_Valid` deasserts the following cycle.
  - `Out_Valid` and `Out_Sum` are stable while `Out_Ready`=0.
- Reset mid-run: Reset takes priority over all events on the same edge.
  - Returns to IDLE and clears acc and count; no `Out_Valid` is produced.
  - A ROM `Data` update still in flight is ignored.
- `Start` and `Reset` on the same edge: Reset wins.

## Structure
- Package `rom_mac_pkg`:
  - State enum: IDLE, COLLECT, LOOKUP, ACCUM, DONE.
  - Constants: `OPERAND_W`=4, `ROM_ADDR_W`=8, `ROM_DATA_W`=8.
  - Function `pack_addr(a,b)` returning {a,b}.
- No sub-module. `ROM_multiplier` stays a sibling instance wired by the parent; the bench instantiates both.

## Test plan
- Reset held 2 cycles → all outputs 0, `Busy`=0. `In_Valid`=1 in IDLE → `In_Ready` stays 0.
- `N_TERMS`=4, `Start`, pairs (3,5),(7,9),(15,15),(0,12) → `Rom_Address` 0x35, 0x79, 0xFF, 0x0C, each with a single-cycle `Rom_Enable`; `Out_Sum`=303; `Out_Valid` high from 2 edges after the last handshake.
- Random `In_Valid` gaps and `Out_Ready` low for 5 cycles → `Out_Valid`=1 and `Out_Sum` stable throughout; `In_Ready`=0 in LOOKUP/ACCUM/DONE; sum still 303.
- `N_TERMS`=16, all pairs (15,15) → `Out_Sum`=3600, no wrap.
- Reset asserted one cycle after the 2nd handshake → IDLE next cycle, `Out_Sum`=0, no `Out_Valid`. A fresh `Start` with (2,2)×4 → 16.
- `Start` pulsed during COLLECT and DONE → ignored; the sum is unchanged. Back-to-back runs: `Start` in the cycle after `Out_Valid` drops → acc cleared and the new sum is correct.

Source files
------------

// File: rtl/rom_mac_pkg.sv
// Shared types and constants for the ROM-multiplier dot-product sequencer.
//   state_t   : sequencer FSM states
//   pack_addr : forms the ROM address {a, b} from an operand pair
package rom_mac_pkg;

  localparam int unsigned OPERAND_W  = 4;
  localparam int unsigned ROM_ADDR_W = 8;
  localparam int unsigned ROM_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    LOOKUP  = 3'd2,
    ACCUM   = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Multiplicand in the high nibble, multiplier in the low nibble.
  function automatic logic [ROM_ADDR_W-1:0] pack_addr(
    input logic [OPERAND_W-1:0] a,
    input logic [OPERAND_W-1:0] b
  );
    return {a, b};
  endfunction

endpackage

// File: rtl/rom_mac_sequencer.sv
// Dot-product sequencer driving an external ROM multiplier.
// Takes N_TERMS operand pairs on a valid/ready stream, looks up each product
// in the ROM (one-cycle registered latency), accumulates and presents the sum.
//   clk, Reset          : clock, synchronous active-high reset
//   Start               : begin a new dot product (IDLE only)
//   In_Valid/In_Ready   : operand pair handshake, In_A/In_B operands
//   Rom_Enable/Address  : registered ROM request
//   Rom_Data            : ROM product, valid the cycle after the enabled edge
//   Out_Valid/Out_Ready : sum handshake, Out_Sum is the accumulator
//   Busy                : sequencer not in IDLE
module rom_mac_sequencer
  import rom_mac_pkg::*;
#(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 12
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [OPERAND_W-1:0]  In_A,
  input  logic [OPERAND_W-1:0]  In_B,
  output logic                  Rom_Enable,
  output logic [ROM_ADDR_W-1:0] Rom_Address,
  input  logic [ROM_DATA_W-1:0] Rom_Data,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [ACC_W-1:0]      Out_Sum,
  output logic                  Busy
);

  localparam int unsigned CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  // Parameter legality, caught at elaboration.
  if (N_TERMS == 0 || N_TERMS > 16) begin : g_bad_terms
    $error("rom_mac_sequencer: N_TERMS must be in 1..16");
  end
  if (ACC_W < ROM_DATA_W + $clog2(N_TERMS)) begin : g_bad_acc
    $error("rom_mac_sequencer: ACC_W too narrow for N_TERMS products");
  end

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [ACC_W-1:0]        acc_q;
  logic [ROM_ADDR_W-1:0]   rom_addr_q;
  logic                    rom_en_q, rom_en_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic                    in_fire;

  assign in_fire = In_Valid && in_ready_q;

  // State register.
  always_ff @(posedge clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = COLLECT;
      COLLECT: if (in_fire) state_d = LOOKUP;
      LOOKUP:  state_d = ACCUM;
      ACCUM:   state_d = (cnt_q == LAST_CNT) ? DONE : COLLECT;
      DONE:    if (Out_Ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so every control output is a flop.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    rom_en_d    = 1'b0;
    busy_d      = 1'b0;
    in_ready_d  = (state_d == COLLECT);
    out_valid_d = (state_d == DONE);
    rom_en_d    = (state_d == LOOKUP);
    busy_d      = (state_d != IDLE);
  end

  // Registered control outputs.
  always_ff @(posedge clk) begin
    if (Reset) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      rom_en_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      rom_en_q    <= rom_en_d;
      busy_q      <= busy_d;
    end
  end

  // Datapath: address capture, term counter and accumulator.
  always_ff @(posedge clk) begin
    if (Reset) begin
      rom_addr_q <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
    end else begin
      if (state_q == IDLE && Start) begin
        cnt_q <= '0;
        acc_q <= '0;
      end
      if (state_q == COLLECT && in_fire) begin
        rom_addr_q <= pack_addr(In_A, In_B);
      end
      // Rom_Data carries the product latched at the end of LOOKUP.
      if (state_q == ACCUM) begin
        acc_q <= acc_q + ACC_W'(Rom_Data);
        if (cnt_q != LAST_CNT) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign In_Ready    = in_ready_q;
  assign Out_Valid   = out_valid_q;
  assign Rom_Enable  = rom_en_q;
  assign Rom_Address = rom_addr_q;
  assign Busy        = busy_q;
  assign Out_Sum     = acc_q;

endmodule
